// File: rtl/mux_4x1_32bit_reg.sv
// 4-input data selector with a zero-latency combinational output and a
// registered, capture-enabled copy for crossing a pipeline boundary.
module mux_4x1_32bit_reg #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  input  logic [1:0]       SELECT,
  input  logic             EN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_REG
);

  // Selection stage: an unresolved select code falls to the default branch
  // so the pipeline sees zeros instead of a propagated X.
  always_comb begin
    OUT = '0;
    case (SELECT)
      2'b00:   OUT = IN0;
      2'b01:   OUT = IN1;
      2'b10:   OUT = IN2;
      2'b11:   OUT = IN3;
      default: OUT = '0;
    endcase
  end

  // Register stage: reset wins over enable; hold when not enabled.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      OUT_REG <= '0;
    end else if (EN) begin
      OUT_REG <= OUT;
    end
  end

endmodule

// File: tb/tb_mux_4x1_32bit_reg.sv
// Directed bench for mux_4x1_32bit_reg: combinational selection, X-select
// handling, synchronous active-low reset, capture enable and hold.
module tb_mux_4x1_32bit_reg;

  logic        clk;
  logic        reset;
  logic [31:0] in0, in1, in2, in3;
  logic [1:0]  select;
  logic        en;
  logic [31:0] out;
  logic [31:0] out_reg;

  int checks = 0;
  int errors = 0;

  mux_4x1_32bit_reg #(.WIDTH(32)) dut (
    .CLK     (clk),
    .RESET   (reset),
    .IN0     (in0),
    .IN1     (in1),
    .IN2     (in2),
    .IN3     (in3),
    .SELECT  (select),
    .EN      (en),
    .OUT     (out),
    .OUT_REG (out_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_result(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_x;
  logic [1:0]  sel_seq [4];
  logic [31:0] out_seq [4];

  initial begin
    reset  = 1'b0;
    en     = 1'b0;
    select = 2'b00;
    in0 = 32'h0000_0000;
    in1 = 32'h0000_0001;
    in2 = 32'h0000_0010;
    in3 = 32'h0000_0011;

    // Reset state
    tick();
    check_result("reset_state", out_reg, 32'h0000_0000);

    // Plan 1: step SELECT at 1-unit intervals between edges
    @(negedge clk);
    reset = 1'b1;
    select = 2'b00; #1 check_result("sel00", out, 32'h0000_0000);
    select = 2'b01; #1 check_result("sel01", out, 32'h0000_0001);
    select = 2'b10; #1 check_result("sel10", out, 32'h0000_0010);
    select = 2'b11; #1 check_result("sel11", out, 32'h0000_0011);

    // Plan 2: unresolved select drives zeros; EN=0 keeps OUT_REG
    @(negedge clk);
    select = 2'bxx;
    #1;
    if ($isunknown(select)) exp_x = 32'h0000_0000;
    else case (select)
      2'b00: exp_x = in0;
      2'b01: exp_x = in1;
      2'b10: exp_x = in2;
      default: exp_x = in3;
    endcase
    check_result("selx_out", out, exp_x);
    tick();
    check_result("selx_hold", out_reg, 32'h0000_0000);

    // Load a nonzero value so the reset below has something to clear
    @(negedge clk);
    en = 1'b1;
    select = 2'b11;
    tick();
    check_result("capture11", out_reg, 32'h0000_0011);

    // Plan 3: reset beats EN; OUT unaffected
    @(negedge clk);
    reset = 1'b0;
    #1 check_result("rst_out_before", out, 32'h0000_0011);
    tick();
    check_result("rst_clear", out_reg, 32'h0000_0000);
    check_result("rst_out_after", out, 32'h0000_0011);

    // Plan 4: one-edge latency, SELECT changed between edges
    @(negedge clk);
    reset = 1'b1;
    select = 2'b10;
    tick();
    check_result("lat_sel10", out_reg, 32'h0000_0010);
    @(negedge clk);
    select = 2'b01;
    tick();
    check_result("lat_sel01", out_reg, 32'h0000_0001);

    // Plan 5: EN=0 holds OUT_REG while OUT tracks inputs
    @(negedge clk);
    en  = 1'b0;
    in3 = 32'hDEAD_BEEF;
    sel_seq = '{2'b11, 2'b00, 2'b10, 2'b11};
    out_seq = '{32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0010, 32'hDEAD_BEEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      select = sel_seq[i];
      #1 check_result($sformatf("hold_out%0d", i), out, out_seq[i]);
      tick();
      check_result($sformatf("hold_reg%0d", i), out_reg, 32'h0000_0001);
    end

    // Bit-position pass-through on distinct patterns with capture
    @(negedge clk);
    en  = 1'b1;
    in0 = 32'hA5A5_5A5A;
    in1 = 32'h8000_0001;
    in2 = 32'hFFFF_FFFF;
    select = 2'b00;
    tick();
    check_result("pat_in0", out_reg, 32'hA5A5_5A5A);
    @(negedge clk);
    select = 2'b01;
    #1 check_result("pat_in1_out", out, 32'h8000_0001);
    tick();
    check_result("pat_in1_reg", out_reg, 32'h8000_0001);
    @(negedge clk);
    select = 2'b10;
    tick();
    check_result("pat_in2", out_reg, 32'hFFFF_FFFF);

    // Plan 6: reset asserted mid-stream, then recapture
    @(negedge clk);
    in3 = 32'h0000_0011;
    select = 2'b11;
    tick();
    check_result("mid_cap", out_reg, 32'h0000_0011);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_result("mid_rst", out_reg, 32'h0000_0000);
    check_result("mid_rst_out", out, 32'h0000_0011);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_result("mid_recap", out_reg, 32'h0000_0011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
